// File: rtl/mmu_split_pkg.sv
// Shared constants and helpers for the MMU split/dispatch path.
// Provides default port count, word and destination widths, a constant
// clog2, and the offset helper used to address a port's flattened data slice.
package mmu_split_pkg;

    localparam int unsigned NumPortsDef    = 10;
    localparam int unsigned DataWidthDef   = 88;
    localparam int unsigned DestWDef       = 4;
    // Default distance between consecutive port slices in a flattened bus.
    localparam int unsigned SliceStrideDef = DataWidthDef;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned acc;
        res = 0;
        acc = 1;
        while (acc < value) begin
            acc = acc << 1;
            res = res + 1;
        end
        return res;
    endfunction

    // Lowest bit of slice `k` in a bus of `stride`-wide slices.
    function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned stride);
        return k * stride;
    endfunction

endpackage

// File: rtl/mmu_sync_fifo.sv
// Synchronous FIFO used as the dispatcher input buffer.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset (empties the FIFO)
//   push_i  - write data_i this cycle (caller guarantees !full_o or pop_i)
//   pop_i   - drop the head entry this cycle (caller guarantees !empty_o)
//   data_i  - write data
//   head_o  - registered head entry, valid when !empty_o
//   full_o  - FIFO_DEPTH entries held
//   empty_o - no entries held
module mmu_sync_fifo
    import mmu_split_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);

    // Pointers are PtrW bits wide and FIFO_DEPTH is a power of two, so the
    // natural overflow gives the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmu_split10_dispatch.sv
// 1-to-NUM_PORTS in-order dispatcher with pulse credit handshakes.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   i_drive     - upstream word valid pulse, data on i_data
//   o_free      - pulse: one input slot released (one upstream credit back)
//   o_drive     - per-port pulse: new word on that port's o_data slice
//   o_data      - flattened port data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_free      - per-port pulse: port consumed its word (credit back)
//   o_err_route - pulse: head word with out-of-range dest was discarded
//   o_err_proto - sticky: overflow push or free of an already-held credit
module mmu_split10_dispatch
    import mmu_split_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = NumPortsDef,
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned DEST_LSB   = 0,
    parameter int unsigned DEST_W     = DestWDef,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_drive,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_free,
    output logic [NUM_PORTS-1:0]            o_drive,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data,
    input  logic [NUM_PORTS-1:0]            i_free,
    output logic                            o_err_route,
    output logic                            o_err_proto
);

    logic [DATA_WIDTH-1:0]           head;
    logic                            full, empty;
    logic [DEST_W-1:0]               dest;
    logic                            dest_ok;
    logic [NUM_PORTS-1:0]            disp_vec;
    logic                            discard, pop, push, drop;

    logic [NUM_PORTS-1:0]            credit_q, credit_d;
    logic [NUM_PORTS-1:0]            drive_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_q, data_d;
    logic                            free_q, err_route_q;
    logic                            err_proto_q, err_proto_d;

    mmu_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (i_data),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign dest    = head[DEST_LSB +: DEST_W];
    assign dest_ok = (32'(dest) < NUM_PORTS);

    always_comb begin
        disp_vec = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!empty && (32'(dest) == k) && credit_q[k]) begin
                disp_vec[k] = 1'b1;
            end
        end
        discard = !empty && !dest_ok;
        pop     = (|disp_vec) || discard;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push    = i_drive && (!full || pop);
        drop    = i_drive && full && !pop;
    end

    always_comb begin
        credit_d = credit_q;
        data_d   = data_q;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            // Dispatch wins over a same-cycle free; that free is flagged below.
            if (disp_vec[k]) begin
                credit_d[k] = 1'b0;
                data_d[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = head;
            end else if (i_free[k]) begin
                credit_d[k] = 1'b1;
            end
        end
        err_proto_d = err_proto_q || drop || (|(i_free & credit_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q    <= '1;
            drive_q     <= '0;
            data_q      <= '0;
            free_q      <= 1'b0;
            err_route_q <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            drive_q     <= disp_vec;
            data_q      <= data_d;
            free_q      <= pop;
            err_route_q <= discard;
            err_proto_q <= err_proto_d;
        end
    end

    assign o_drive     = drive_q;
    assign o_data      = data_q;
    assign o_free      = free_q;
    assign o_err_route = err_route_q;
    assign o_err_proto = err_proto_q;

endmodule

// File: tb/tb_mmu_split10_dispatch.sv
module tb_mmu_split10_dispatch;

    localparam int unsigned NP = 10;
    localparam int unsigned DW = 88;

    logic              clk;
    logic              rst;
    logic              i_drive;
    logic [DW-1:0]     i_data;
    logic              o_free;
    logic [NP-1:0]     o_drive;
    logic [NP*DW-1:0]  o_data;
    logic [NP-1:0]     i_free;
    logic              o_err_route;
    logic              o_err_proto;

    mmu_split10_dispatch dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_drive     (o_drive),
        .o_data      (o_data),
        .i_free      (i_free),
        .o_err_route (o_err_route),
        .o_err_proto (o_err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          route;
        int unsigned   port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input int unsigned tag, input int unsigned dest);
        logic [DW-1:0] w;
        w = '0;
        w[87:80] = 8'hA5;
        w[79:4]  = 76'(tag);
        w[3:0]   = 4'(dest);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic route, input int unsigned port, input logic [DW-1:0] d);
        exp_t e;
        e.route = route;
        e.port  = port;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] w);
        i_drive = 1'b1;
        i_data  = w;
        step();
        i_drive = 1'b0;
    endtask

    task automatic free_port(input int unsigned k);
        i_free = NP'(1) << k;
        step();
        i_free = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every port pulse or route error consumes the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (o_drive != '0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_drive: got %0h want none at %0t", o_drive, $time);
                end else begin
                    e = sb.pop_front();
                    chk("mon_route_flag", 128'(e.route), 128'(0));
                    chk("mon_drive_port", 128'(o_drive), 128'(NP'(1) << e.port));
                    chk("mon_data", 128'(o_data[e.port*DW +: DW]), 128'(e.data));
                end
            end
            if (o_err_route) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_route_err: got 1 want 0 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("mon_route_expected", 128'(e.route), 128'(1));
                end
            end
        end
    end

    initial begin
        int ucred, sent, ndrv, first_c, last_c, nroute;
        logic [DW-1:0] w;

        rst     = 1'b1;
        i_drive = 1'b0;
        i_data  = '0;
        i_free  = '0;
        idle(2);
        chk("rst_drive", 128'(o_drive), 128'(0));
        chk("rst_free", 128'(o_free), 128'(0));
        chk("rst_err_route", 128'(o_err_route), 128'(0));
        chk("rst_err_proto", 128'(o_err_proto), 128'(0));
        chk("rst_data_zero", 128'(o_data == '0), 128'(1));
        rst = 1'b0;
        idle(1);

        // Basic dispatch: two-cycle latency on port 3.
        w = mkword(0, 3);
        exp_push(1'b0, 3, w);
        send(w);
        chk("basic_c1_drive", 128'(o_drive), 128'(0));
        step();
        chk("basic_c2_drive", 128'(o_drive), 128'(10'h008));
        chk("basic_c2_free", 128'(o_free), 128'(1));
        chk("basic_c2_slice", 128'(o_data[3*DW +: DW]), 128'(88'hA5_0000_0000_0000_0000_0003));
        idle(2);
        free_port(3);
        idle(1);

        // Head-of-line blocking on port 5.
        exp_push(1'b0, 5, mkword(1, 5));
        exp_push(1'b0, 5, mkword(2, 5));
        exp_push(1'b0, 1, mkword(3, 1));
        i_drive = 1'b1;
        i_data  = mkword(1, 5);
        step();
        i_data  = mkword(2, 5);
        step();
        chk("hol_first_drive", 128'(o_drive), 128'(10'h020));
        chk("hol_first_free", 128'(o_free), 128'(1));
        i_data  = mkword(3, 1);
        step();
        i_drive = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hol_stall_drive", 128'(o_drive), 128'(0));
            chk("hol_stall_free", 128'(o_free), 128'(0));
            step();
        end
        i_free = 10'h020;
        step();
        i_free = '0;
        chk("hol_rel_c1", 128'(o_drive), 128'(0));
        step();
        chk("hol_rel_p5", 128'(o_drive), 128'(10'h020));
        step();
        chk("hol_rel_p1", 128'(o_drive), 128'(10'h002));
        idle(1);
        free_port(5);
        free_port(1);
        idle(1);

        // Route error: dest 12 discarded, next word on port 0 proceeds.
        exp_push(1'b1, 0, '0);
        exp_push(1'b0, 0, mkword(4, 0));
        i_drive = 1'b1;
        i_data  = mkword(9, 12);
        step();
        i_data  = mkword(4, 0);
        step();
        i_drive = 1'b0;
        chk("route_err", 128'(o_err_route), 128'(1));
        chk("route_free", 128'(o_free), 128'(1));
        chk("route_no_drive", 128'(o_drive), 128'(0));
        step();
        chk("route_next_p0", 128'(o_drive), 128'(10'h001));
        chk("route_err_cleared", 128'(o_err_route), 128'(0));
        idle(2);
        free_port(0);
        idle(3);

        // Throughput: credit-driven upstream, immediate downstream frees.
        ucred = 2;
        sent = 0;
        ndrv = 0;
        first_c = -1;
        last_c = -1;
        nroute = 0;
        for (int c = 0; c < 60; c++) begin
            i_free = o_drive;
            if (o_drive != '0) begin
                ndrv++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (o_err_route) nroute++;
            if (o_free) ucred++;
            if (sent < 20 && ucred > 0) begin
                w = mkword(100 + sent, sent % 10);
                exp_push(1'b0, sent % 10, w);
                i_drive = 1'b1;
                i_data  = w;
                ucred--;
                sent++;
            end else begin
                i_drive = 1'b0;
            end
            step();
        end
        i_free  = '0;
        i_drive = 1'b0;
        chk("tput_delivered", 128'(ndrv), 128'(20));
        chk("tput_back_to_back", 128'(last_c - first_c), 128'(19));
        chk("tput_first_latency", 128'(first_c), 128'(2));
        chk("tput_route_errs", 128'(nroute), 128'(0));
        chk("tput_no_proto", 128'(o_err_proto), 128'(0));

        // Protocol errors: free of a held credit, then overflow push.
        free_port(2);
        chk("proto_free_held", 128'(o_err_proto), 128'(1));
        w = mkword(200, 6);
        exp_push(1'b0, 6, w);
        send(w);
        step();
        chk("proto_x_p6", 128'(o_drive), 128'(10'h040));
        exp_push(1'b0, 6, mkword(201, 6));
        exp_push(1'b0, 6, mkword(202, 6));
        i_drive = 1'b1;
        i_data  = mkword(201, 6);
        step();
        i_data  = mkword(202, 6);
        step();
        i_data  = mkword(203, 6);
        step();
        i_drive = 1'b0;
        for (int r = 0; r < 3; r++) begin
            free_port(6);
            idle(3);
        end
        idle(2);
        chk("proto_drop_consumed", 128'(sb.size()), 128'(0));
        chk("proto_sticky", 128'(o_err_proto), 128'(1));

        // Reset mid-operation: port 4 credit taken, two words buffered.
        w = mkword(300, 4);
        exp_push(1'b0, 4, w);
        send(w);
        idle(2);
        i_drive = 1'b1;
        i_data  = mkword(301, 4);
        step();
        i_data  = mkword(302, 4);
        step();
        i_drive = 1'b0;
        idle(1);
        chk("mid_pending_empty_sb", 128'(sb.size()), 128'(0));
        rst = 1'b1;
        step();
        chk("mid_rst_drive", 128'(o_drive), 128'(0));
        chk("mid_rst_free", 128'(o_free), 128'(0));
        chk("mid_rst_proto", 128'(o_err_proto), 128'(0));
        chk("mid_rst_route", 128'(o_err_route), 128'(0));
        chk("mid_rst_data", 128'(o_data == '0), 128'(1));
        rst = 1'b0;
        w = mkword(303, 4);
        exp_push(1'b0, 4, w);
        send(w);
        chk("mid_c1_drive", 128'(o_drive), 128'(0));
        step();
        chk("mid_c2_p4", 128'(o_drive), 128'(10'h010));
        chk("mid_c2_free", 128'(o_free), 128'(1));
        idle(5);
        chk("final_sb_empty", 128'(sb.size()), 128'(0));
        chk("final_no_proto", 128'(o_err_proto), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
